// File: rtl/ldr_pkg.sv
// ldr_pkg: shared state encodings, widths and lane constants for byte_loader
package ldr_pkg;
    typedef enum logic [2:0] {CLEAR, COLLECT, LOAD, DONE, IDLE} ldr_state_t;
    localparam int LDR_NUM_BYTES = 4;
    localparam int LDR_IDX_W = 2;
    localparam logic [LDR_IDX_W-1:0] LANE0 = 2'b00;
    localparam logic [LDR_IDX_W-1:0] LANE1 = 2'b01;
    localparam logic [LDR_IDX_W-1:0] LANE2 = 2'b10;
    localparam logic [LDR_IDX_W-1:0] LANE3 = 2'b11;
endpackage

// File: rtl/byte_loader_sync_rise.sv
// sync_rise: SYNC_STAGES-deep synchroniser for an asynchronous pin plus rising-edge detect
module sync_rise #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   stb_d;
    // shift the pin through the synchroniser and keep one cycle of history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            stb_d <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], d};
            stb_d <= sync[SYNC_STAGES-1];
        end
    end
    assign rise = sync[SYNC_STAGES-1] & ~stb_d;
endmodule

// File: rtl/byte_loader.sv
// byte_loader: sequences strobed pin bytes into lanes 0..3 of the register memory; LDR_TIMEOUT_EN adds an inter-byte timeout abort
module byte_loader
    import ldr_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst_LDR_n,
    input  logic [7:0]           BYTE_IN,
    input  logic                 BYTE_STB,
    input  logic                 START,
    output logic [7:0]           MEM_IN,
    output logic                 MEM_LOAD,
    output logic [LDR_IDX_W-1:0] MEM_LOAD_VAL,
    output logic                 rst_MEM,
    output logic                 WORD_DONE,
    output logic                 BUSY,
    output logic [LDR_IDX_W-1:0] BYTE_IDX,
    output logic                 TIMEOUT
);
    ldr_state_t           state, nxt;
    logic [LDR_IDX_W-1:0] idx;
    logic                 rise, tmo;

    sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_stb (
        .clk   (clk),
        .rst_n (rst_LDR_n),
        .d     (BYTE_STB),
        .rise  (rise)
    );

    // next state: START outranks everything, a byte outranks a timeout
    always_comb begin
        nxt = (START && state != CLEAR) ? CLEAR :
              (state == CLEAR)          ? COLLECT :
              (state == COLLECT)        ? (rise ? LOAD : (tmo ? CLEAR : COLLECT)) :
              (state == LOAD)           ? ((idx == LANE3) ? DONE : COLLECT) :
              IDLE;
    end

    // state, lane index and all outputs registered from the next state
    always_ff @(posedge clk or negedge rst_LDR_n) begin
        if (!rst_LDR_n) begin
            state        <= CLEAR;
            rst_MEM      <= 1'b1;
            BUSY         <= 1'b1;
            MEM_LOAD     <= 1'b0;
            WORD_DONE    <= 1'b0;
            MEM_IN       <= '0;
            MEM_LOAD_VAL <= LANE0;
            idx          <= LANE0;
        end else begin
            state     <= nxt;
            rst_MEM   <= nxt == CLEAR;
            BUSY      <= nxt == CLEAR || nxt == COLLECT || nxt == LOAD;
            MEM_LOAD  <= nxt == LOAD;
            WORD_DONE <= nxt == DONE;
            if (nxt == LOAD) begin
                MEM_IN       <= BYTE_IN;
                MEM_LOAD_VAL <= idx;
            end
            if (nxt == CLEAR)
                idx <= LANE0;
            else if (state == LOAD)
                idx <= idx + 2'd1;
        end
    end

    assign BYTE_IDX = idx;

`ifdef LDR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;

    assign tmo = state == COLLECT && idx != LANE0 && cnt == CW'(TIMEOUT_CYCLES);

    // count idle cycles between bytes of a started word; pulse TIMEOUT on abort
    always_ff @(posedge clk or negedge rst_LDR_n) begin
        if (!rst_LDR_n) begin
            cnt     <= '0;
            TIMEOUT <= 1'b0;
        end else begin
            cnt     <= (state == COLLECT && nxt == COLLECT && idx != LANE0) ? cnt + CW'(1) : '0;
            TIMEOUT <= tmo & ~rise & ~START;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign tmo            = 1'b0;
    assign TIMEOUT        = 1'b0;
`endif
endmodule
